axi4_lite_slave_read_responder: RTL and testbench

Slave-side AXI4-Lite read engine that drives the responder half of the slave read interface (arready, rdata, rresp, rvalid).
- Accepts one read address at a time and decodes it against a single memory window.
- Fetches one data word from a backing memory port with variable latency.
- Returns the R beat with full rready backpressure.
- Sits between the slave read interface signals and the slave memory model.

---
 rtl/axi4_lite_slave_read_responder_pkg.sv | 32 +++
 rtl/axi4_lite_slave_read_responder_addr_decoder.sv | 53 +++++
 rtl/axi4_lite_slave_read_responder.sv | 133 +++++++++++++
 tb/tb_axi4_lite_slave_read_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_slave_read_responder_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_slave_read_responder_pkg
//   Shared AXI4-Lite definitions for the slave read responder and its address
//   decoder. It holds the default bus widths, the AXI response codes and the
//   read-responder state encoding.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package axi4_lite_slave_read_responder_pkg;

  // Default bus widths for the AXI4-Lite slave blocks.
  localparam int AXI_ADDRESS_WIDTH = 32;
  localparam int AXI_DATA_WIDTH    = 32;

  // AXI response codes. EXOKAY has no meaning on AXI4-Lite.
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  // Read-responder states, encoded as plain constants.
  localparam logic [1:0] RD_IDLE     = 2'd0;
  localparam logic [1:0] RD_MEM_WAIT = 2'd1;
  localparam logic [1:0] RD_RESP     = 2'd2;

  // Width of a word index into a window of mem_size_bytes bytes.
  function automatic int word_index_width(input int mem_size_bytes, input int data_width);
    return $clog2(mem_size_bytes / (data_width / 8));
  endfunction

endpackage

// File: rtl/axi4_lite_slave_read_responder_addr_decoder.sv
// -----------------------------------------------------------------------------
// axi4_lite_read_addr_decoder
//   Combinational decode of an AXI4-Lite address against one memory window.
//   Ports:
//     addr      in   ADDRESS_WIDTH  byte address to decode
//     prot      in   3              AxPROT; only bit 0 (privileged) is used
//     in_range  out  1              addr lies inside [MEM_BASE, MEM_BASE+MEM_SIZE_BYTES)
//     priv_ok   out  1              access passes the privilege filter
//     word_idx  out  IDX_W          word index of addr within the window
// -----------------------------------------------------------------------------
module axi4_lite_read_addr_decoder
  import axi4_lite_slave_read_responder_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH  = AXI_ADDRESS_WIDTH,
  parameter int                       DATA_WIDTH     = AXI_DATA_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] MEM_BASE       = 'h0000_1000,
  parameter int                       MEM_SIZE_BYTES = 4096,
  parameter bit                       PRIV_ONLY      = 1'b0,
  localparam int                      IDX_W          = word_index_width(MEM_SIZE_BYTES, DATA_WIDTH)
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [2:0]               prot,
  output logic                     in_range,
  output logic                     priv_ok,
  output logic [IDX_W-1:0]         word_idx
);

  localparam int BYTE_LSB = $clog2(DATA_WIDTH / 8);

  // One extra bit so a window that touches the top of the address space
  // does not wrap its upper limit back to zero.
  logic [ADDRESS_WIDTH:0]   addr_ext;
  logic [ADDRESS_WIDTH:0]   base_ext;
  logic [ADDRESS_WIDTH:0]   limit_ext;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic                     unused_prot;

  assign addr_ext  = {1'b0, addr};
  assign base_ext  = {1'b0, MEM_BASE};
  assign limit_ext = base_ext + (ADDRESS_WIDTH + 1)'(MEM_SIZE_BYTES);
  assign in_range  = (addr_ext >= base_ext) && (addr_ext < limit_ext);

  // Low byte-lane bits are dropped, so unaligned addresses hit the
  // containing word.
  assign offset   = addr - MEM_BASE;
  assign word_idx = IDX_W'(offset >> BYTE_LSB);

  assign priv_ok = !PRIV_ONLY || prot[0];

  // Secure/instruction attributes do not affect this window.
  assign unused_prot = &{1'b0, prot[2:1]};

endmodule

// File: rtl/axi4_lite_slave_read_responder.sv
// -----------------------------------------------------------------------------
// axi4_lite_slave_read_responder
//   AXI4-Lite slave read engine. It accepts one AR at a time, decodes it
//   against a single memory window, fetches one word from a variable-latency
//   memory port and returns the R beat under rready backpressure.
//   Ports:
//     aclk, aresetn             clock, asynchronous active-low reset
//     araddr/arprot/arvalid     AR channel from the master
//     arready                   AR ready (registered)
//     rdata/rresp/rvalid        R channel to the master (registered)
//     rready                    R ready from the master
//     mem_req/mem_addr          one-cycle read strobe and word index to memory
//     mem_rvalid/mem_rdata      memory read return
//     mem_err                   memory error, qualified by mem_rvalid
// -----------------------------------------------------------------------------
module axi4_lite_slave_read_responder
  import axi4_lite_slave_read_responder_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH  = AXI_ADDRESS_WIDTH,
  parameter int                       DATA_WIDTH     = AXI_DATA_WIDTH,
  parameter logic [ADDRESS_WIDTH-1:0] MEM_BASE       = 'h0000_1000,
  parameter int                       MEM_SIZE_BYTES = 4096,
  parameter bit                       PRIV_ONLY      = 1'b0,
  localparam int                      MEM_ADDR_WIDTH = word_index_width(MEM_SIZE_BYTES, DATA_WIDTH)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDRESS_WIDTH-1:0]  araddr,
  input  logic [2:0]                arprot,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  output logic                      mem_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_err
);

  logic [1:0]                state;
  logic                      dec_in_range;
  logic                      dec_priv_ok;
  logic [MEM_ADDR_WIDTH-1:0] dec_word_idx;

  // Decode straight off the AR bus; the result is only consumed on the
  // handshake edge, which is equivalent to latching araddr/arprot first.
  axi4_lite_read_addr_decoder #(
    .ADDRESS_WIDTH  (ADDRESS_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .MEM_BASE       (MEM_BASE),
    .MEM_SIZE_BYTES (MEM_SIZE_BYTES),
    .PRIV_ONLY      (PRIV_ONLY)
  ) u_decoder (
    .addr     (araddr),
    .prot     (arprot),
    .in_range (dec_in_range),
    .priv_ok  (dec_priv_ok),
    .word_idx (dec_word_idx)
  );

  // NOTE: every register below uses non-blocking assignment so all state
  // updates on an edge see the pre-edge values; blocking here would create
  // order-dependent simulation and mismatches with the synthesized flops.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= RD_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= OKAY;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      // mem_req is a strobe: high only on the cycle after it is set.
      mem_req <= 1'b0;

      case (state)
        RD_IDLE: begin
          if (arready && arvalid) begin
            arready <= 1'b0;
            if (!dec_in_range) begin
              rresp  <= DECERR;
              rdata  <= '0;
              rvalid <= 1'b1;
              state  <= RD_RESP;
            end else if (!dec_priv_ok) begin
              rresp  <= SLVERR;
              rdata  <= '0;
              rvalid <= 1'b1;
              state  <= RD_RESP;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= dec_word_idx;
              state    <= RD_MEM_WAIT;
            end
          end else begin
            // Covers the first edge after reset as well as the idle hold.
            arready <= 1'b1;
          end
        end

        RD_MEM_WAIT: begin
          // Sampled from the mem_req cycle onward, so a zero-wait memory
          // can answer in the same cycle as the strobe.
          if (mem_rvalid) begin
            rdata  <= mem_rdata;
            rresp  <= mem_err ? SLVERR : OKAY;
            rvalid <= 1'b1;
            state  <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            state   <= RD_IDLE;
          end
        end

        default: begin
          rvalid  <= 1'b0;
          arready <= 1'b0;
          state   <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_read_responder.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_slave_read_responder
//   Self-checking bench. dut0 uses PRIV_ONLY=0, dut1 uses PRIV_ONLY=1; both
//   share the AR payload, rready and the memory model, with separate arvalid.
//   Expected R beats are queued when an AR is issued and compared when the
//   R handshake is observed.
// -----------------------------------------------------------------------------
module tb_axi4_lite_slave_read_responder;
  import axi4_lite_slave_read_responder_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 10;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid0, arvalid1;
  logic          rready;
  logic          mem_rvalid, mem_err;
  logic [DW-1:0] mem_rdata;

  logic          arready0, rvalid0, mem_req0;
  logic [DW-1:0] rdata0;
  logic [1:0]    rresp0;
  logic [IW-1:0] mem_addr0;
  logic          arready1, rvalid1, mem_req1;
  logic [DW-1:0] rdata1;
  logic [1:0]    rresp1;
  logic [IW-1:0] mem_addr1;

  always #5 aclk = ~aclk;

  axi4_lite_slave_read_responder #(
    .ADDRESS_WIDTH (AW), .DATA_WIDTH (DW), .MEM_BASE (32'h0000_1000),
    .MEM_SIZE_BYTES (4096), .PRIV_ONLY (1'b0)
  ) dut0 (
    .aclk (aclk), .aresetn (aresetn), .araddr (araddr), .arprot (arprot),
    .arvalid (arvalid0), .arready (arready0), .rdata (rdata0), .rresp (rresp0),
    .rvalid (rvalid0), .rready (rready), .mem_req (mem_req0), .mem_addr (mem_addr0),
    .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata), .mem_err (mem_err)
  );

  axi4_lite_slave_read_responder #(
    .ADDRESS_WIDTH (AW), .DATA_WIDTH (DW), .MEM_BASE (32'h0000_1000),
    .MEM_SIZE_BYTES (4096), .PRIV_ONLY (1'b1)
  ) dut1 (
    .aclk (aclk), .aresetn (aresetn), .araddr (araddr), .arprot (arprot),
    .arvalid (arvalid1), .arready (arready1), .rdata (rdata1), .rresp (rresp1),
    .rvalid (rvalid1), .rready (rready), .mem_req (mem_req1), .mem_addr (mem_addr1),
    .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata), .mem_err (mem_err)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_pulses = 0;
  int mem_lat = 0;
  logic [DW-1:0] mem_data_cfg = '0;
  logic          mem_err_cfg = 1'b0;
  logic          sel = 1'b0;

  // Views of whichever DUT the current stimulus targets.
  logic          s_arready, s_rvalid, s_mem_req;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic [IW-1:0] s_mem_addr;
  assign s_arready  = sel ? arready1  : arready0;
  assign s_rvalid   = sel ? rvalid1   : rvalid0;
  assign s_mem_req  = sel ? mem_req1  : mem_req0;
  assign s_rdata    = sel ? rdata1    : rdata0;
  assign s_rresp    = sel ? rresp1    : rresp0;
  assign s_mem_addr = sel ? mem_addr1 : mem_addr0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // Memory model: answers each mem_req after mem_lat cycles (0 = same cycle).
  initial begin
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge aclk);
      if (mem_req0 || mem_req1) begin
        mem_pulses++;
        repeat (mem_lat) @(posedge aclk);
        if (mem_lat > 0) #1;
        mem_rvalid = 1'b1;
        mem_rdata  = mem_data_cfg;
        mem_err    = mem_err_cfg;
        @(posedge aclk);
        #1;
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = '0;
      end
    end
  end

  // Scoreboard: every R handshake must match the oldest queued expectation.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (rvalid0 && rready) begin
        check("r0_outstanding", q0.size(), 1);
        if (q0.size() > 0) begin
          e0 = q0.pop_front();
          check("r0_rdata", rdata0, e0.data);
          check("r0_rresp", rresp0, e0.resp);
        end
      end
      if (rvalid1 && rready) begin
        check("r1_outstanding", q1.size(), 1);
        if (q1.size() > 0) begin
          e1 = q1.pop_front();
          check("r1_rdata", rdata1, e1.data);
          check("r1_rresp", rresp1, e1.resp);
        end
      end
    end
  end

  task automatic set_arvalid(input logic v);
    if (sel) arvalid1 = v;
    else     arvalid0 = v;
  endtask

  // Called at posedge+1 with arvalid already high; returns at posedge+1 just
  // after the handshake edge (or after the wait budget runs out).
  task automatic ar_wait(output logic got, output int waits);
    got   = 1'b0;
    waits = 0;
    while (!got && waits < 20) begin
      @(negedge aclk);
      got = s_arready;
      waits++;
      @(posedge aclk);
      #1;
    end
    set_arvalid(1'b0);
  endtask

  task automatic issue_read(input string name, input logic [AW-1:0] addr,
                            input logic [2:0] prot, input logic [DW-1:0] exp_data,
                            input logic [1:0] exp_resp, input logic exp_mem,
                            input logic [IW-1:0] exp_idx, input int hold,
                            input logic early, input logic [AW-1:0] early_addr,
                            output int hs_waits);
    exp_t          e;
    logic          got, rv;
    int            hs, n, p0;
    logic [DW-1:0] sd;
    logic [1:0]    sr;
    e.data = exp_data;
    e.resp = exp_resp;
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
    p0     = mem_pulses;
    araddr = addr;
    arprot = prot;
    rready = (hold == 0);
    set_arvalid(1'b1);
    ar_wait(got, hs_waits);
    check({name, "_ar_accepted"}, got, 1);
    if (!got) return;
    hs = cyc;

    rv = 1'b0;
    n  = 0;
    while (!rv && n < 40) begin
      @(negedge aclk);
      n++;
      if (n == 1) begin
        check({name, "_mem_req"}, s_mem_req, exp_mem);
        if (exp_mem) check({name, "_mem_addr"}, s_mem_addr, exp_idx);
      end
      if (n == 2) check({name, "_mem_req_pulse"}, s_mem_req, 0);
      rv = s_rvalid;
      if (!rv) begin
        @(posedge aclk);
        #1;
      end
    end
    check({name, "_rvalid_seen"}, rv, 1);
    if (!rv) return;
    check({name, "_latency"}, cyc - hs + 1, exp_mem ? 2 + mem_lat : 1);

    sd = s_rdata;
    sr = s_rresp;
    for (int h = 0; h < hold; h++) begin
      @(posedge aclk);
      #1;
      if (early && h == 0) begin
        araddr = early_addr;
        arprot = 3'b001;
        set_arvalid(1'b1);
      end
      @(negedge aclk);
      check({name, "_hold_rvalid"}, s_rvalid, 1);
      check({name, "_hold_rdata"}, s_rdata, sd);
      check({name, "_hold_rresp"}, s_rresp, sr);
      check({name, "_hold_arready"}, s_arready, 0);
    end
    if (hold > 0) begin
      @(posedge aclk);
      #1;
      rready = 1'b1;
      @(negedge aclk);
    end
    @(posedge aclk);
    #1;
    check({name, "_mem_pulses"}, mem_pulses - p0, exp_mem);
    if (!early) begin
      @(negedge aclk);
      check({name, "_post_rvalid"}, s_rvalid, 0);
      check({name, "_post_arready"}, s_arready, 1);
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    logic got;
    araddr   = '0;
    arprot   = 3'b000;
    arvalid0 = 1'b0;
    arvalid1 = 1'b0;
    rready   = 1'b1;

    // Reset values and arready rising on the first edge after release.
    @(negedge aclk);
    check("rst_arready", arready0, 0);
    check("rst_rvalid", rvalid0, 0);
    check("rst_rdata", rdata0, 0);
    check("rst_rresp", rresp0, 0);
    check("rst_mem_req", mem_req0, 0);
    check("rst_mem_addr", mem_addr0, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("arready_before_edge", arready0, 0);
    @(negedge aclk);
    check("arready_after_edge", arready0, 1);
    check("arready1_after_edge", arready1, 1);
    @(posedge aclk);
    #1;

    // Basic in-range read, 2-cycle memory.
    sel = 1'b0;
    mem_lat = 2; mem_data_cfg = 32'hDEAD_BEEF; mem_err_cfg = 1'b0;
    issue_read("t1", 32'h1008, 3'b001, 32'hDEAD_BEEF, OKAY, 1'b1, 10'd2, 0, 1'b0, '0, w);

    // Decode errors at and beyond both window edges, including the top of
    // the address space.
    issue_read("t2_2000", 32'h2000, 3'b001, 32'h0, DECERR, 1'b0, '0, 0, 1'b0, '0, w);
    issue_read("t2_0fff", 32'h0FFF, 3'b001, 32'h0, DECERR, 1'b0, '0, 0, 1'b0, '0, w);
    issue_read("t2_top", 32'hFFFF_FFFC, 3'b001, 32'h0, DECERR, 1'b0, '0, 0, 1'b0, '0, w);

    // Window edges inside, zero/one-cycle memory, unaligned, unprivileged
    // access allowed when PRIV_ONLY=0.
    mem_lat = 0; mem_data_cfg = 32'h0BAD_F00D;
    issue_read("t2_last", 32'h1FFC, 3'b000, 32'h0BAD_F00D, OKAY, 1'b1, 10'd1023, 0, 1'b0, '0, w);
    mem_lat = 1; mem_data_cfg = 32'h1111_2222;
    issue_read("t2_first", 32'h1000, 3'b001, 32'h1111_2222, OKAY, 1'b1, 10'd0, 0, 1'b0, '0, w);
    mem_lat = 0; mem_data_cfg = 32'h3333_4444;
    issue_read("t2_unal", 32'h1007, 3'b001, 32'h3333_4444, OKAY, 1'b1, 10'd1, 0, 1'b0, '0, w);

    // Privilege filter on dut1.
    sel = 1'b1;
    issue_read("t3_unpriv", 32'h1010, 3'b000, 32'h0, SLVERR, 1'b0, '0, 0, 1'b0, '0, w);
    mem_lat = 1; mem_data_cfg = 32'hCAFE_F00D;
    issue_read("t3_priv", 32'h1010, 3'b001, 32'hCAFE_F00D, OKAY, 1'b1, 10'd4, 0, 1'b0, '0, w);
    sel = 1'b0;

    // Memory error response.
    mem_lat = 1; mem_data_cfg = 32'h1234_5678; mem_err_cfg = 1'b1;
    issue_read("t4", 32'h1ABC, 3'b001, 32'h1234_5678, SLVERR, 1'b1, 10'd687, 0, 1'b0, '0, w);
    mem_err_cfg = 1'b0;

    // Backpressure with an early second AR that must wait for the R handshake.
    mem_lat = 1; mem_data_cfg = 32'hA5A5_5A5A;
    issue_read("t5a", 32'h1100, 3'b001, 32'hA5A5_5A5A, OKAY, 1'b1, 10'h40, 5, 1'b1, 32'h1104, w);
    mem_lat = 0; mem_data_cfg = 32'h7777_8888;
    issue_read("t5b", 32'h1104, 3'b001, 32'h7777_8888, OKAY, 1'b1, 10'h41, 0, 1'b0, '0, w);
    check("t5b_accept_edge", w, 1);

    // Reset during MEM_WAIT; the late memory response must be dropped.
    mem_lat = 3; mem_data_cfg = 32'h5555_AAAA;
    araddr = 32'h1020; arprot = 3'b001;
    arvalid0 = 1'b1;
    ar_wait(got, w);
    check("t6_ar_accepted", got, 1);
    @(negedge aclk);
    check("t6_mem_req", mem_req0, 1);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(negedge aclk);
    check("t6_rst_arready", arready0, 0);
    check("t6_rst_rvalid", rvalid0, 0);
    check("t6_rst_mem_req", mem_req0, 0);
    check("t6_rst_mem_addr", mem_addr0, 0);
    check("t6_rst_rdata", rdata0, 0);
    check("t6_rst_rresp", rresp0, 0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check("t6_arready_back", arready0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("t6_no_rvalid", rvalid0, 0);
      check("t6_no_mem_req", mem_req0, 0);
    end
    @(posedge aclk);
    #1;

    // Normal operation after the mid-transaction reset.
    mem_lat = 2; mem_data_cfg = 32'h0F0F_F0F0;
    issue_read("t6_recover", 32'h1024, 3'b001, 32'h0F0F_F0F0, OKAY, 1'b1, 10'd9, 0, 1'b0, '0, w);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
